// File: rtl/queen_search_controller_pkg.sv
// Shared types and constants for the 8-queen search controller.
// State encoding for the control FSM lives here.
package queen_search_controller_pkg;

  localparam int N     = 8;
  localparam int ROW_W = 3;

  typedef enum logic [3:0] {
    IDLE,
    PUSH0,
    WAIT,
    CHECK,
    COMPARE,
    PLACE,
    ADV,
    NEXTCOL,
    BACK,
    BCHK,
    EMIT,
    FIN
  } state_t;

endpackage

// File: rtl/queen_search_controller_depth_counter.sv
// Saturating up/down search depth counter.
// Never wraps: holds at N-1 going up and at 0 going down.
module search_depth_counter #(
  parameter int N     = 8,
  parameter int ROW_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic at_last,
  output logic at_zero
);

  logic [ROW_W-1:0] depth_q;

  assign at_last = (depth_q == ROW_W'(N - 1));
  assign at_zero = (depth_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
    end else if (clr) begin
      depth_q <= '0;
    end else if (inc && !at_last) begin
      depth_q <= depth_q + 1'b1;
    end else if (dec && !at_zero) begin
      depth_q <= depth_q - 1'b1;
    end
  end

endmodule

// File: rtl/queen_search_controller.sv
// Control FSM for the 8-queen backtracking solver.
// Sequences stack push/pop, conflict checks, placement and output.
module queen_search_controller #(
  parameter int N     = queen_search_controller_pkg::N,
  parameter int ROW_W = queen_search_controller_pkg::ROW_W
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic cout,
  input  logic down_counter_zero,
  input  logic row_zero,
  input  logic last_column,
  input  logic safe,
  input  logic stack_ready,
  input  logic underflow,
  output logic enable_output,
  output logic register_load,
  output logic count,
  output logic load_counter,
  output logic push,
  output logic pop,
  output logic increament_row,
  output logic increament_column,
  output logic ready,
  output logic done,
  output logic found,
  output logic out_valid
);

  import queen_search_controller_pkg::*;

  state_t st_q, st_d;
  state_t ret_q, ret_d;
  logic   done_q, done_d;
  logic   found_q, found_d;
  logic   d_clr, d_inc, d_dec;
  logic   at_last, at_zero;

  search_depth_counter #(
    .N     (N),
    .ROW_W (ROW_W)
  ) u_depth (
    .clk     (clk),
    .reset   (reset),
    .clr     (d_clr),
    .inc     (d_inc),
    .dec     (d_dec),
    .at_last (at_last),
    .at_zero (at_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= IDLE;
      ret_q   <= IDLE;
      done_q  <= 1'b0;
      found_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      ret_q   <= ret_d;
      done_q  <= done_d;
      found_q <= found_d;
    end
  end

  always_comb begin
    st_d              = st_q;
    ret_d             = ret_q;
    done_d            = done_q;
    found_d           = found_q;
    d_clr             = 1'b0;
    d_inc             = 1'b0;
    d_dec             = 1'b0;
    enable_output     = 1'b0;
    register_load     = 1'b0;
    count             = 1'b0;
    load_counter      = 1'b0;
    push              = 1'b0;
    pop               = 1'b0;
    increament_row    = 1'b0;
    increament_column = 1'b0;
    ready             = 1'b0;
    out_valid         = 1'b0;
    unique case (st_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          d_clr   = 1'b1;
          done_d  = 1'b0;
          found_d = 1'b0;
          st_d    = PUSH0;
        end
      end
      PUSH0: begin
        if (stack_ready) begin
          push  = 1'b1;
          ret_d = CHECK;
          st_d  = WAIT;
        end
      end
      WAIT: begin
        if (stack_ready) st_d = ret_q;
      end
      CHECK: begin
        if (cout) begin
          found_d = 1'b0;
          st_d    = FIN;
        end else if (row_zero) begin
          st_d = PLACE;
        end else begin
          load_counter = 1'b1;
          st_d         = COMPARE;
        end
      end
      COMPARE: begin
        if (!safe) begin
          st_d = NEXTCOL;
        end else if (down_counter_zero) begin
          st_d = PLACE;
        end else begin
          count = 1'b1;
        end
      end
      PLACE: begin
        register_load = 1'b1;
        if (at_last) begin
          st_d = EMIT;
        end else begin
          d_inc = 1'b1;
          st_d  = ADV;
        end
      end
      ADV: begin
        if (stack_ready) begin
          push           = 1'b1;
          increament_row = 1'b1;
          ret_d          = CHECK;
          st_d           = WAIT;
        end
      end
      NEXTCOL: begin
        if (last_column) begin
          st_d = BACK;
        end else if (stack_ready) begin
          push              = 1'b1;
          pop               = 1'b1;
          increament_column = 1'b1;
          ret_d             = CHECK;
          st_d              = WAIT;
        end
      end
      BACK: begin
        if (stack_ready) begin
          pop   = 1'b1;
          ret_d = BCHK;
          st_d  = WAIT;
        end
      end
      BCHK: begin
        if (underflow) begin
          found_d = 1'b0;
          st_d    = FIN;
        end else begin
          d_dec = 1'b1;
          st_d  = NEXTCOL;
        end
      end
      EMIT: begin
        // one row per visit, top of stack first, popped as it goes
        if (stack_ready) begin
          enable_output = 1'b1;
          out_valid     = 1'b1;
          pop           = 1'b1;
          st_d          = WAIT;
          if (at_zero) begin
            found_d = 1'b1;
            ret_d   = FIN;
          end else begin
            d_dec = 1'b1;
            ret_d = EMIT;
          end
        end
      end
      FIN: begin
        done_d = 1'b1;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign done  = done_q | (st_q == FIN);
  assign found = found_q;

endmodule

// File: tb/tb_queen_search_controller.sv
// Bench for queen_search_controller with a behavioural
// stack/datapath model and a row scoreboard.
module tb_queen_search_controller;

  logic clk = 1'b0;
  logic reset, start, cout;
  logic down_counter_zero, row_zero, last_column, safe;
  logic stack_ready, underflow;
  logic enable_output, register_load, count, load_counter;
  logic push, pop, increament_row, increament_column;
  logic ready, done, found, out_valid;

  always #5 clk = ~clk;

  queen_search_controller dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .cout              (cout),
    .down_counter_zero (down_counter_zero),
    .row_zero          (row_zero),
    .last_column       (last_column),
    .safe              (safe),
    .stack_ready       (stack_ready),
    .underflow         (underflow),
    .enable_output     (enable_output),
    .register_load     (register_load),
    .count             (count),
    .load_counter      (load_counter),
    .push              (push),
    .pop               (pop),
    .increament_row    (increament_row),
    .increament_column (increament_column),
    .ready             (ready),
    .done              (done),
    .found             (found),
    .out_valid         (out_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mon_viol = 0;

  // behavioural stack + board + other-queen counter
  int         lat = 0;
  int         busy;
  int         sp;
  logic [2:0] srow [0:8];
  logic [2:0] scol [0:8];
  logic [2:0] bcol [0:7];
  logic [2:0] cnt;
  logic       uf_q;
  logic       force_uf = 1'b0;
  logic [2:0] trow, tcol, oc, cd;
  logic [7:0] obus;

  assign trow = (sp > 0) ? srow[sp-1] : 3'd0;
  assign tcol = (sp > 0) ? scol[sp-1] : 3'd0;
  assign row_zero = (trow == 3'd0);
  assign last_column = (tcol == 3'd7);
  assign down_counter_zero = (cnt == 3'd0);
  assign stack_ready = (busy == 0);
  assign underflow = uf_q | force_uf;
  assign cout = 1'b0;
  assign obus = enable_output ? (8'b1 << bcol[trow]) : 8'h00;

  always_comb begin
    oc = bcol[cnt];
    cd = (oc > tcol) ? oc - tcol : tcol - oc;
    safe = !((cd == 3'd0) || (cd == trow - cnt));
  end

  always @(posedge clk) begin
    if (reset) begin
      sp   <= 0;
      busy <= 0;
      cnt  <= 3'd0;
      uf_q <= 1'b0;
      for (int i = 0; i < 8; i++) bcol[i] <= 3'd0;
    end else begin
      if (busy > 0) busy <= busy - 1;
      if (push || pop) busy <= lat;
      if (push && pop) begin
        if (increament_column && sp > 0)
          scol[sp-1] <= scol[sp-1] + 3'd1;
      end else if (push && sp < 9) begin
        srow[sp] <= increament_row ? trow + 3'd1 : 3'd0;
        scol[sp] <= 3'd0;
        sp <= sp + 1;
      end else if (pop) begin
        if (sp > 0) sp <= sp - 1;
        uf_q <= (sp <= 1);
      end
      if (register_load) bcol[trow] <= tcol;
      if (load_counter) cnt <= trow - 3'd1;
      else if (count) cnt <= cnt - 3'd1;
    end
  end

  // protocol invariants, sampled away from the clock edge
  always @(negedge clk) begin
    if (!reset) begin
      if (increament_row && increament_column) begin
        mon_viol++;
        if (mon_viol < 20) $display("FAIL inv_incr both=1 want 0");
      end
      if (!push && (increament_row || increament_column)) begin
        mon_viol++;
        if (mon_viol < 20) $display("FAIL inv_incr_nopush got 1 want 0");
      end
      if (out_valid && !enable_output) begin
        mon_viol++;
        if (mon_viol < 20) $display("FAIL inv_out_en got 0 want 1");
      end
      if (count && down_counter_zero) begin
        mon_viol++;
        if (mon_viol < 20) $display("FAIL inv_count_dcz got 1 want 0");
      end
      if ((push || pop) && !stack_ready) begin
        mon_viol++;
        if (mon_viol < 20) $display("FAIL inv_req_busy got 1 want 0");
      end
    end
  end

  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  function automatic logic [8:0] strobes();
    return {enable_output, register_load, count, load_counter,
            push, pop, increament_row, increament_column, out_valid};
  endfunction

  task automatic push_solution();
    logic [7:0] sol [0:7];
    sol = '{8'h08, 8'h02, 8'h40, 8'h04, 8'h20, 8'h80, 8'h10, 8'h01};
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(sol[i]);
  endtask

  task automatic run_search(input int inj, input bit inj_emit,
                            input int max_cyc, output bit to);
    bit emitted;
    emitted = 1'b0;
    to = 1'b1;
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == inj) start = 1'b1;
      if (out_valid) begin
        got_q.push_back(obus);
        if (inj_emit && !emitted) begin
          start = 1'b1;
          emitted = 1'b1;
        end
      end
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_rows(input string tag);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_rows count got %0d want %0d",
               tag, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s_row got %h want %h", tag, g, e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", ready);
    end
    n_checks++;
    if (strobes() !== 9'd0) begin
      n_fail++; $display("FAIL reset_strobes got %b want 0", strobes());
    end
    n_checks++;
    if ({done, found} !== 2'b00) begin
      n_fail++; $display("FAIL reset_done got %b want 00", {done, found});
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_ready got %b want 1", ready);
    end
  endtask

  task automatic test_solve(input string tag, input int l,
                            input int bound);
    bit to;
    lat = l;
    mon_viol = 0;
    push_solution();
    run_search(-1, 1'b0, bound, to);
    n_checks++;
    if (to !== 1'b0) begin
      n_fail++; $display("FAIL %s_timeout got 1 want 0", tag);
    end
    n_checks++;
    if ({done, found} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s_done got %b want 11", tag, {done, found});
    end
    check_rows(tag);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ready, done, found} !== 3'b111) begin
      n_fail++;
      $display("FAIL %s_hold got %b want 111", tag, {ready, done, found});
    end
    n_checks++;
    if (mon_viol !== 0) begin
      n_fail++; $display("FAIL %s_inv got %0d want 0", tag, mon_viol);
    end
  endtask

  task automatic test_underflow();
    bit to;
    lat = 0;
    mon_viol = 0;
    force_uf = 1'b1;
    exp_q.delete();
    run_search(-1, 1'b0, 5000, to);
    force_uf = 1'b0;
    n_checks++;
    if (to !== 1'b0) begin
      n_fail++; $display("FAIL uf_timeout got 1 want 0");
    end
    n_checks++;
    if ({done, found} !== 2'b10) begin
      n_fail++; $display("FAIL uf_done got %b want 10", {done, found});
    end
    check_rows("uf");
    n_checks++;
    if (mon_viol !== 0) begin
      n_fail++; $display("FAIL uf_inv got %0d want 0", mon_viol);
    end
  endtask

  task automatic test_reset_mid();
    bit to, seen;
    lat = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (load_counter) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++; $display("FAIL mid_load_counter got 0 want 1");
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_ready got %b want 1", ready);
    end
    n_checks++;
    if ({strobes(), done, found} !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_strobes got %b want 0", {strobes(), done, found});
    end
    reset = 1'b0;
    test_solve("mid", 0, 20000);
    to = 1'b0;
  endtask

  task automatic test_start_ignored();
    bit to;
    int extra;
    lat = 0;
    mon_viol = 0;
    extra = 0;
    push_solution();
    run_search(200, 1'b1, 20000, to);
    n_checks++;
    if (to !== 1'b0) begin
      n_fail++; $display("FAIL ign_timeout got 1 want 0");
    end
    check_rows("ign");
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL ign_extra_rows got %0d want 0", extra);
    end
    n_checks++;
    if ({ready, done, found} !== 3'b111) begin
      n_fail++;
      $display("FAIL ign_hold got %b want 111", {ready, done, found});
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_solve("solve", 0, 20000);
    test_solve("slow", 3, 30000);
    test_underflow();
    test_reset_mid();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
